// File: rtl/sram_pkg.sv
// Shared constants for the bit-write-enable SRAM and its read pipeline.
package sram_pkg;
  localparam int RW_READ_FIRST  = 0;
  localparam int RW_WRITE_FIRST = 1;
  localparam int RD_LAT_MAX     = 4;
endpackage

// File: rtl/sram_rd_pipe.sv
// Output delay line carrying {valid, err, data}; the final data register
// only loads on a valid result so the output holds between results.
module sram_rd_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             src_vld,
  input  logic             src_err,
  input  logic [WIDTH-1:0] src_dat,
  output logic             vld,
  output logic             err,
  output logic [WIDTH-1:0] dat
);
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] err_p;
  logic              last_vld;
  logic [WIDTH-1:0]  last_dat;
  logic [WIDTH-1:0]  q_p;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p <= '0;
      err_p <= '0;
    end else begin
      vld_p[0] <= src_vld;
      err_p[0] <= src_err;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        err_p[i] <= err_p[i-1];
      end
    end
  end

  if (STAGES == 1) begin : g_direct
    assign last_vld = src_vld;
    assign last_dat = src_dat;
  end else begin : g_delay
    logic [WIDTH-1:0] dly_p [STAGES-1];
    always_ff @(posedge clock) begin
      dly_p[0] <= src_dat;
      for (int i = 1; i < STAGES - 1; i++) begin
        dly_p[i] <= dly_p[i-1];
      end
    end
    assign last_vld = vld_p[STAGES-2];
    assign last_dat = dly_p[STAGES-2];
  end

  // final stage: the output word is reset and held unless a result lands
  always_ff @(posedge clock) begin
    if (reset) begin
      q_p <= '0;
    end else if (last_vld) begin
      q_p <= last_dat;
    end
  end

  assign vld = vld_p[STAGES-1];
  assign err = err_p[STAGES-1];
  assign dat = q_p;
endmodule

// File: rtl/sram_bw_param.sv
// Single-port SRAM with per-bit write enables, pipelined read latency,
// selectable read-first/write-first result and out-of-range error reporting.
module sram_bw_param
  import sram_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 64,
  parameter int RD_LAT  = 1,
  parameter int RW_MODE = 0,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [DATA_W-1:0] BWEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  output logic              ERR
);
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX || DEPTH < 2) begin : g_bad_param
    $error("sram_bw_param: illegal RD_LAT=%0d or DEPTH=%0d", RD_LAT, DEPTH);
  end

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              acc_p0;
  logic              oob_p0;
  logic [DATA_W-1:0] old_p0;
  logic [DATA_W-1:0] merged_p0;
  logic              vld_p0;
  logic              err_p0;
  logic [DATA_W-1:0] dat_p0;

  // stage 0: access decode, bit merge and result selection
  assign acc_p0    = ~CEN & ~reset;
  assign oob_p0    = ({1'b0, A} >= DEPTH_X);
  assign old_p0    = oob_p0 ? '0 : mem[A];
  assign merged_p0 = (old_p0 & BWEN) | (D & ~BWEN);
  assign vld_p0    = acc_p0 & (WEN | oob_p0 | (RW_MODE == RW_WRITE_FIRST));
  assign err_p0    = acc_p0 & oob_p0;
  assign dat_p0    = oob_p0 ? '0 : (WEN ? old_p0 : merged_p0);

  always_ff @(posedge clock) begin
    if (acc_p0 && !WEN && !oob_p0) begin
      mem[A] <= merged_p0;
    end
  end

  // stages 1..RD_LAT: result delay line
  sram_rd_pipe #(
    .WIDTH  (DATA_W),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clock   (clock),
    .reset   (reset),
    .src_vld (vld_p0),
    .src_err (err_p0),
    .src_dat (dat_p0),
    .vld     (Q_VALID),
    .err     (ERR),
    .dat     (Q)
  );
endmodule

// File: doc/sram_bw_param.md
SRAM_BW_PARAM -- requirements
Module: sram_bw_param

Interface
REQ-001 Parameter DATA_W, default 128, word width in bits.
REQ-002 Parameter DEPTH, default 64, number of words; ADDR_W = clog2(DEPTH), minimum 1.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-004 Parameter RW_MODE, default 0; 0 = read-first, 1 = write-first.
REQ-005 Port clock, input, 1, the single clock; all logic on rising edge.
REQ-006 Port reset, input, 1, reset: synchronous, active-high.
REQ-007 Port CEN, input, 1, active-low chip enable.
REQ-008 Port WEN, input, 1, active-low write enable; high = read.
REQ-009 Port BWEN, input, DATA_W, active-low per-bit write enable.
REQ-010 Port A, input, ADDR_W, word address.
REQ-011 Port D, input, DATA_W, write data.
REQ-012 Port Q, output, DATA_W, read data; holds its value between results.
REQ-013 Port Q_VALID, output, 1, one-cycle pulse marking a new Q.
REQ-014 Port ERR, output, 1, one-cycle pulse, aligned with Q_VALID, marking an out-of-range access.

Function
REQ-015 An access SHALL be sampled on a rising edge with CEN=0 and reset=0; CEN=1 means no access, and memory and pipeline inputs are unchanged.
REQ-016 Write (WEN=0) SHALL update mem[A] bit i to D[i] only where BWEN[i]=0; other bits keep their old value.
REQ-017 Read (WEN=1) SHALL present mem[A] on Q with Q_VALID=1 exactly RD_LAT cycles after the sampling edge.
REQ-018 Reads SHALL be fully pipelined: one access per cycle sustained, results returned in issue order, no bubbles.
REQ-019 A read issued the cycle after a write to the same A SHALL return the updated word.
REQ-020 RW_MODE=1: a write SHALL also produce Q_VALID after RD_LAT cycles, with Q = the merged post-write word.
REQ-021 RW_MODE=0: a write SHALL produce no Q_VALID; Q holds its previous value.
REQ-022 If A >= DEPTH, a write SHALL be suppressed. A read SHALL return Q=0. In both cases ERR=1 and Q_VALID=1 SHALL pulse after RD_LAT cycles, regardless of RW_MODE.
REQ-023 Q SHALL change only in a cycle where Q_VALID=1.

Reset
REQ-024 While reset=1: Q=0, Q_VALID=0, ERR=0, and every pipeline valid bit is cleared.
REQ-025 Accesses presented while reset=1 SHALL be ignored; no write takes effect.
REQ-026 Reads in flight when reset asserts SHALL be discarded; no Q_VALID pulse follows for them.
REQ-027 Memory contents SHALL NOT be cleared by reset; after reset, unwritten words read as X in simulation.

Structure
REQ-028 Shared package sram_pkg SHALL hold RW_READ_FIRST=0, RW_WRITE_FIRST=1 and RD_LAT_MAX=4.
REQ-029 The output delay line SHALL be one sub-module, sram_rd_pipe, parametrised by width and RD_LAT and carrying {valid, err, data}; the storage array stays in sram_bw_param.
REQ-030 The illegal-parameter check (RD_LAT outside 1..4, DEPTH < 2) SHALL be an elaboration-time error.

Verification
REQ-031 Defaults. Write A=5, D=all ones, BWEN=all zeros; then read A=5 -> Q=all ones, Q_VALID high one cycle after the read edge.
REQ-032 Partial write. Write A=3, D=0, BWEN low only on bits [7:0], over a word of all ones -> read returns all ones with bits [7:0]=0.
REQ-033 RD_LAT=3. Reads of A=0,1,2 on consecutive cycles -> three Q_VALID pulses on consecutive cycles, starting 3 cycles after the first read, data in order.
REQ-034 RW_MODE=1. Write A=7, D=0xA5 in the low byte -> Q_VALID after RD_LAT with Q low byte 0xA5; with RW_MODE=0 there is no Q_VALID.
REQ-035 DEPTH=48. Read A=50 -> Q=0, ERR=1, Q_VALID=1; a write to A=50 leaves words 0..47 unchanged.
REQ-036 RD_LAT=4. Issue a read, then assert reset 2 cycles later for one cycle -> no Q_VALID at all; Q=0 after reset.
